// File: rtl/rc_pwm_gen.sv
// RC-style PWM transmitter: fixed-length period with a programmable high pulse.
// Width writes are clamped, held in a pending register, and applied only at period boundaries.
module rc_pwm_gen #(
  parameter int unsigned PERIOD_US  = 14000,
  parameter int unsigned MIN_US     = 1100,
  parameter int unsigned MAX_US     = 1900,
  parameter int unsigned DEFAULT_US = 1500,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_clk,
  input  logic             enable,
  input  logic [CNT_W-1:0] width_in,
  input  logic             width_wr,
  output logic             pwm_out,
  output logic             period_start,
  output logic             clamp_flag,
  output logic [CNT_W-1:0] width_active,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_US - 1);
  localparam logic [CNT_W-1:0] MIN_W       = CNT_W'(MIN_US);
  localparam logic [CNT_W-1:0] MAX_W       = CNT_W'(MAX_US);
  localparam logic [CNT_W-1:0] DEF_W       = CNT_W'(DEFAULT_US);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] width_active_q, width_active_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             pending_valid_q, pending_valid_d;
  logic             pwm_out_q, pwm_out_d;
  logic             period_start_q, period_start_d;
  logic             clamp_flag_q, clamp_flag_d;
  logic             start;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    width_active_d  = width_active_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    clamp_flag_d    = 1'b0;
    start           = 1'b0;

    if (pwm_clk) begin
      case (state_q)
        ST_IDLE: begin
          if (enable) start = 1'b1;
        end
        ST_HIGH: begin
          cnt_d = cnt_q + ONE;
          if (cnt_q == width_active_q - ONE) state_d = ST_LOW;
        end
        ST_LOW: begin
          if (cnt_q == PERIOD_LAST) begin
            if (enable) begin
              start = 1'b1;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Reload consumes the pending value as it stood before any write on this same cycle.
    if (start) begin
      state_d = ST_HIGH;
      cnt_d   = '0;
      if (pending_valid_q) begin
        width_active_d  = pending_q;
        pending_valid_d = 1'b0;
      end
    end

    if (width_wr) begin
      pending_valid_d = 1'b1;
      if (width_in < MIN_W) begin
        pending_d    = MIN_W;
        clamp_flag_d = 1'b1;
      end else if (width_in > MAX_W) begin
        pending_d    = MAX_W;
        clamp_flag_d = 1'b1;
      end else begin
        pending_d = width_in;
      end
    end

    pwm_out_d      = (state_d == ST_HIGH);
    period_start_d = start;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      width_active_q  <= DEF_W;
      pending_q       <= DEF_W;
      pending_valid_q <= 1'b0;
      pwm_out_q       <= 1'b0;
      period_start_q  <= 1'b0;
      clamp_flag_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      width_active_q  <= width_active_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      pwm_out_q       <= pwm_out_d;
      period_start_q  <= period_start_d;
      clamp_flag_q    <= clamp_flag_d;
    end
  end

  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;
  assign clamp_flag   = clamp_flag_q;
  assign width_active = width_active_q;
  assign busy         = (state_q != ST_IDLE);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_rc_pwm_gen.sv
// Bench for rc_pwm_gen at a 1/10 time scale: directed vectors and sequences plus a
// randomized phase, all checked against a period-position reference model.
module tb_rc_pwm_gen;

  localparam int P   = 1400;
  localparam int MN  = 110;
  localparam int MX  = 190;
  localparam int DEF = 150;

  logic        clk = 1'b0;
  logic        rst;
  logic        pwm_clk;
  logic        enable;
  logic [15:0] width_in;
  logic        width_wr;
  logic        pwm_out;
  logic        period_start;
  logic        clamp_flag;
  logic [15:0] width_active;
  logic        busy;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic rand_tick = 1'b0;

  rc_pwm_gen #(.PERIOD_US(P), .MIN_US(MN), .MAX_US(MX), .DEFAULT_US(DEF), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pwm_clk(pwm_clk), .enable(enable),
    .width_in(width_in), .width_wr(width_wr), .pwm_out(pwm_out),
    .period_start(period_start), .clamp_flag(clamp_flag),
    .width_active(width_active), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / tick ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) pwm_clk = rand_tick ? ($urandom_range(0, 1) == 1) : 1'b1;

  // ---------------- reference model ----------------
  // The model tracks position within the period: output is high while pos < width.
  bit running;
  int pos, cur_w, pend;
  bit pend_v, m_ps, m_clamp, m_pwm;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      running = 0; pos = 0; cur_w = DEF; pend = DEF; pend_v = 0;
      m_ps = 0; m_clamp = 0; m_pwm = 0;
    end else begin
      bit start;
      int w;
      start = 0;
      if (pwm_clk) begin
        if (running) begin
          pos++;
          if (pos == P) begin
            if (enable) start = 1;
            else begin running = 0; pos = 0; end
          end
        end else if (enable) start = 1;
      end
      m_ps = start;
      if (start) begin
        running = 1; pos = 0;
        if (pend_v) begin cur_w = pend; pend_v = 0; end
      end
      m_clamp = 0;
      if (width_wr) begin
        w = int'(width_in);
        m_clamp = (w < MN) || (w > MX);
        pend = (w < MN) ? MN : (w > MX) ? MX : w;
        pend_v = 1;
      end
      m_pwm = running && (pos < cur_w);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst)
      check("model{pwm,ps,clamp,busy,width}",
            {12'd0, pwm_out, period_start, clamp_flag, busy, width_active},
            {12'd0, m_pwm, m_ps, m_clamp, running, 16'(cur_w)});
  end

  // ---------------- driver tasks ----------------
  task automatic write_width(input int v);
    width_in = 16'(v); width_wr = 1'b1;
    @(negedge clk);
    width_wr = 1'b0;
  endtask

  task automatic wait_ps(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (period_start !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
    if (n >= 4000) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic measure_high(output int hi);
    int s;
    s = cyc;
    while (pwm_out === 1'b1 && (cyc - s) < 4000) @(negedge clk);
    hi = cyc - s;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int   wr_val;
    logic exp_clamp;
    int   exp_w;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int hi, rise, seen, n;
    vecs[0] = '{50,  1'b1, 110};
    vecs[1] = '{250, 1'b1, 190};
    vecs[2] = '{140, 1'b0, 140};
    vecs[3] = '{109, 1'b1, 110};
    vecs[4] = '{110, 1'b0, 110};
    vecs[5] = '{190, 1'b0, 190};
    vecs[6] = '{191, 1'b1, 190};
    vecs[7] = '{0,   1'b1, 110};

    rst = 1'b1; enable = 1'b0; width_in = '0; width_wr = 1'b0; pwm_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_pwm_out", pwm_out, 0);
    check("rst_period_start", period_start, 0);
    check("rst_clamp_flag", clamp_flag, 0);
    check("rst_busy", busy, 0);
    check("rst_width_active", width_active, DEF);

    // First period after enable, with a mid-pulse write
    enable = 1'b1;
    @(negedge clk);
    check("first_rise_pwm", pwm_out, 1);
    check("first_rise_ps", period_start, 1);
    check("first_busy", busy, 1);
    rise = cyc;
    repeat (10) @(negedge clk);
    write_width(180);
    measure_high(hi);
    check("first_pulse_width", cyc - rise, DEF);
    wait_ps("second_ps");
    check("period_len", cyc - rise, P);
    check("second_width_active", width_active, 180);
    measure_high(hi);
    check("second_pulse_width", hi, 180);

    // Clamping table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      write_width(vecs[i].wr_val);
      check($sformatf("clamp_flag[%0d]", i), clamp_flag, vecs[i].exp_clamp);
      @(negedge clk);
      check($sformatf("clamp_clear[%0d]", i), clamp_flag, 0);
      wait_ps($sformatf("vec_ps[%0d]", i));
      check($sformatf("vec_width_active[%0d]", i), width_active, vecs[i].exp_w);
      measure_high(hi);
      check($sformatf("vec_pulse[%0d]", i), hi, vecs[i].exp_w);
    end

    // Disable mid-pulse: full pulse, full period, then idle
    wait_ps("dis_ps");
    rise = cyc;
    repeat (20) @(negedge clk);
    enable = 1'b0;
    measure_high(hi);
    check("dis_pulse_full", cyc - rise, 110);
    n = 0;
    while (busy === 1'b1 && n < 4000) begin @(negedge clk); n++; end
    check("dis_idle_at_boundary", cyc - rise, P);
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (pwm_out !== 1'b0 || period_start !== 1'b0 || busy !== 1'b0) seen++;
    end
    check("dis_quiet", seen, 0);
    enable = 1'b1;
    @(negedge clk);
    check("reen_ps", period_start, 1);
    check("reen_pwm", pwm_out, 1);

    // Boundary collision: write lands on the reload cycle
    write_width(120);
    repeat (1398) @(negedge clk);
    width_in = 16'd170; width_wr = 1'b1;
    @(negedge clk);
    width_wr = 1'b0;
    check("coll_ps", period_start, 1);
    check("coll_width_active", width_active, 120);
    measure_high(hi);
    check("coll_pulse", hi, 120);
    wait_ps("coll_next_ps");
    check("coll_next_width", width_active, 170);

    // Reset mid-pulse
    repeat (70) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstmid_pwm", pwm_out, 0);
    check("rstmid_width", width_active, DEF);
    check("rstmid_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_ps("rstmid_restart");
    check("rstmid_restart_width", width_active, DEF);
    measure_high(hi);
    check("rstmid_restart_pulse", hi, DEF);

    // Randomized phase against the model
    rand_tick = 1'b1;
    repeat (30000) begin
      @(negedge clk);
      if ($urandom_range(0, 2999) == 0) enable = ~enable;
      width_wr = ($urandom_range(0, 199) == 0);
      if (width_wr) width_in = 16'($urandom_range(0, 300));
    end
    width_wr = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
